// File: rtl/regwrite_tracker.sv
// Tracks the destination register of the instruction in EX as it moves through M and W,
// and from that state produces the forwarding selects and hazard stalls for a classic
// five-stage pipeline. A saturating counter records how many cycles were lost to
// hazard stalls.
module regwrite_tracker #(
    // Saturation value of the stall counter; kept as a parameter so a narrower limit can
    // be exercised without billions of stall cycles.
    parameter logic [31:0] CntMax = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  writeregE,
    input  logic        memtoregE,
    input  logic        stallall,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [4:0]  rsE,
    input  logic [4:0]  rtE,
    input  logic        branchD,
    output logic [1:0]  forwardAE,
    output logic [1:0]  forwardBE,
    output logic        forwardAD,
    output logic        forwardBD,
    output logic        stallF,
    output logic        stallD,
    output logic        flushE,
    output logic [31:0] stall_cnt
);

    logic [4:0] writeregM;
    logic       memtoregM;
    logic [4:0] writeregW;

    logic       lwstall;
    logic       branchstall;
    logic       hazardStall;
    logic       matchED;
    logic       matchMD;

    // Follow the producer down M and W; a global memory stall freezes the whole pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            writeregM <= 5'd0;
            memtoregM <= 1'b0;
            writeregW <= 5'd0;
        end else if (!stallall) begin
            writeregM <= writeregE;
            memtoregM <= memtoregE;
            writeregW <= writeregM;
        end
    end

    // Select the freshest producer for each EX operand; M wins over W, register 0 never forwards.
    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (rsE != 5'd0 && rsE == writeregM) begin
            forwardAE = 2'b10;
        end else if (rsE != 5'd0 && rsE == writeregW) begin
            forwardAE = 2'b01;
        end
        if (rtE != 5'd0 && rtE == writeregM) begin
            forwardBE = 2'b10;
        end else if (rtE != 5'd0 && rtE == writeregW) begin
            forwardBE = 2'b01;
        end
    end

    // Branch operands compared in ID can only be taken from the M-stage result.
    always_comb begin
        forwardAD = (rsD != 5'd0) && (rsD == writeregM);
        forwardBD = (rtD != 5'd0) && (rtD == writeregM);
    end

    // Load-use and branch-compare hazards; both collapse into one stall/flush request.
    always_comb begin
        matchED     = (writeregE != 5'd0) && (writeregE == rsD || writeregE == rtD);
        matchMD     = memtoregM && (writeregM != 5'd0) && (writeregM == rsD || writeregM == rtD);
        lwstall     = memtoregE && matchED;
        branchstall = branchD && (matchED || matchMD);
        hazardStall = lwstall || branchstall;
        stallF      = hazardStall;
        stallD      = hazardStall;
        flushE      = hazardStall;
    end

    // Count stalled cycles, saturating, and freeze along with the pipe on a memory stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (!stallall && hazardStall && stall_cnt != CntMax) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_regwrite_tracker.sv
module tb_regwrite_tracker;

    logic        clk;
    logic        rst;
    logic [4:0]  writeregE;
    logic        memtoregE;
    logic        stallall;
    logic [4:0]  rsD, rtD, rsE, rtE;
    logic        branchD;

    logic [1:0]  forwardAE, forwardBE, satFwdAE, satFwdBE;
    logic        forwardAD, forwardBD, satFwdAD, satFwdBD;
    logic        stallF, stallD, flushE, satStallF, satStallD, satFlushE;
    logic [31:0] stall_cnt, satCnt;

    int checks = 0;
    int failures = 0;

    // Reference state kept by the bench.
    logic [4:0]  mWr, wWr;
    logic        mMem;
    logic [31:0] mCnt, sCnt;

    typedef struct {
        string       tag;
        logic [1:0]  fae;
        logic [1:0]  fbe;
        logic        fad;
        logic        fbd;
        logic        stall;
        logic [31:0] cnt;
        logic [31:0] scnt;
    } expT;

    expT expQ[$];

    regwrite_tracker dut (
        .clk(clk), .rst(rst), .writeregE(writeregE), .memtoregE(memtoregE),
        .stallall(stallall), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE), .branchD(branchD),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .forwardAD(forwardAD),
        .forwardBD(forwardBD), .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .stall_cnt(stall_cnt)
    );

    // Narrow saturation limit so the saturating behaviour is reachable.
    regwrite_tracker #(.CntMax(32'd3)) dutSat (
        .clk(clk), .rst(rst), .writeregE(writeregE), .memtoregE(memtoregE),
        .stallall(stallall), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE), .branchD(branchD),
        .forwardAE(satFwdAE), .forwardBE(satFwdBE), .forwardAD(satFwdAD),
        .forwardBD(satFwdBD), .stallF(satStallF), .stallD(satStallD), .flushE(satFlushE),
        .stall_cnt(satCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] fwdE(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        if (src == mWr) return 2'b10;
        if (src == wWr) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic expStall();
        logic eHit, mHit;
        eHit = (writeregE != 5'd0) && (writeregE == rsD || writeregE == rtD);
        mHit = mMem && (mWr != 5'd0) && (mWr == rsD || mWr == rtD);
        return (memtoregE && eHit) || (branchD && (eHit || mHit));
    endfunction

    task automatic modelReset();
        mWr = 5'd0; wWr = 5'd0; mMem = 1'b0; mCnt = 32'd0; sCnt = 32'd0;
    endtask

    task automatic drive(input logic [4:0] we, input logic me, input logic sa,
                         input logic [4:0] rsd, input logic [4:0] rtd,
                         input logic [4:0] rse, input logic [4:0] rte, input logic br);
        writeregE = we; memtoregE = me; stallall = sa;
        rsD = rsd; rtD = rtd; rsE = rse; rtE = rte; branchD = br;
    endtask

    // Push what the outputs must be now, let them settle, then pop and compare.
    task automatic sampleCheck(input string tag);
        expT e;
        e.tag = tag;
        e.fae = fwdE(rsE);
        e.fbe = fwdE(rtE);
        e.fad = (rsD != 5'd0) && (rsD == mWr);
        e.fbd = (rtD != 5'd0) && (rtD == mWr);
        e.stall = expStall();
        e.cnt = mCnt;
        e.scnt = sCnt;
        expQ.push_back(e);
        #1;
        e = expQ.pop_front();
        checkVal({e.tag, ".fAE"}, {30'd0, forwardAE}, {30'd0, e.fae});
        checkVal({e.tag, ".fBE"}, {30'd0, forwardBE}, {30'd0, e.fbe});
        checkVal({e.tag, ".fAD"}, {31'd0, forwardAD}, {31'd0, e.fad});
        checkVal({e.tag, ".fBD"}, {31'd0, forwardBD}, {31'd0, e.fbd});
        checkVal({e.tag, ".stallF"}, {31'd0, stallF}, {31'd0, e.stall});
        checkVal({e.tag, ".stallD"}, {31'd0, stallD}, {31'd0, e.stall});
        checkVal({e.tag, ".flushE"}, {31'd0, flushE}, {31'd0, e.stall});
        checkVal({e.tag, ".cnt"}, stall_cnt, e.cnt);
        checkVal({e.tag, ".satCnt"}, satCnt, e.scnt);
    endtask

    // Advance one rising edge, updating the reference state, and return at the falling edge.
    task automatic clockEdge();
        logic st;
        st = expStall();
        @(posedge clk);
        if (!rst && !stallall) begin
            if (st && mCnt != 32'hFFFF_FFFF) mCnt = mCnt + 32'd1;
            if (st && sCnt != 32'd3) sCnt = sCnt + 32'd1;
            wWr  = mWr;
            mWr  = writeregE;
            mMem = memtoregE;
        end
        @(negedge clk);
    endtask

    task automatic cycle(input string tag, input logic [4:0] we, input logic me,
                         input logic sa, input logic [4:0] rsd, input logic [4:0] rtd,
                         input logic [4:0] rse, input logic [4:0] rte, input logic br);
        drive(we, me, sa, rsd, rtd, rse, rte, br);
        sampleCheck(tag);
        clockEdge();
    endtask

    initial begin
        rst = 1'b1;
        drive(5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        modelReset();
        #2;
        sampleCheck("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Producer 8 forwarded from M, then W, then gone.
        cycle("prod8", 5'd8, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        drive(5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8, 5'd0, 1'b0);
        sampleCheck("fwdM");
        checkVal("fwdM.const", {30'd0, forwardAE}, 32'd2);
        clockEdge();
        drive(5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8, 5'd0, 1'b0);
        sampleCheck("fwdW");
        checkVal("fwdW.const", {30'd0, forwardAE}, 32'd1);
        clockEdge();
        cycle("fwdNone", 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8, 5'd0, 1'b0);

        // Load-use stall, then the bubble clears it and the load forwards from M.
        drive(5'd9, 1'b1, 1'b0, 5'd0, 5'd9, 5'd0, 5'd0, 1'b0);
        sampleCheck("lwStall");
        checkVal("lwStall.const", {31'd0, stallD}, 32'd1);
        clockEdge();
        drive(5'd0, 1'b0, 1'b0, 5'd0, 5'd9, 5'd0, 5'd9, 1'b0);
        sampleCheck("lwBubble");
        checkVal("lwBubble.cnt", stall_cnt, 32'd1);
        checkVal("lwBubble.fBE", {30'd0, forwardBE}, 32'd2);
        clockEdge();

        // Branch against an ALU result in EX, then forwarded from M without stalling.
        cycle("brStallE", 5'd5, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 5'd0, 1'b1);
        drive(5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 5'd0, 1'b1);
        sampleCheck("brFwdM");
        checkVal("brFwdM.fAD", {31'd0, forwardAD}, 32'd1);
        checkVal("brFwdM.stall", {31'd0, stallF}, 32'd0);
        clockEdge();

        // Register 0 never matches.
        cycle("zero", 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1);
        cycle("zeroM", 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1);

        // Branch waiting on a load that has reached M; then lw+branch counted once.
        cycle("ldToM", 5'd6, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 5'd0, 1'b0);
        cycle("brStallM", 5'd0, 1'b0, 1'b0, 5'd0, 5'd6, 5'd0, 5'd0, 1'b1);
        cycle("lwAndBr", 5'd10, 1'b1, 1'b0, 5'd10, 5'd0, 5'd0, 5'd0, 1'b1);

        // Same register in M and W: M wins.
        cycle("dupA", 5'd11, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        cycle("dupB", 5'd11, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        cycle("dupPrio", 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd11, 5'd11, 1'b0);

        // Memory stall freezes M/W and the counter even during a load-use hazard.
        cycle("preHold", 5'd2, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        cycle("hold3", 5'd3, 1'b0, 1'b1, 5'd0, 5'd0, 5'd2, 5'd0, 1'b0);
        cycle("hold4", 5'd4, 1'b1, 1'b1, 5'd0, 5'd4, 5'd2, 5'd0, 1'b0);
        cycle("hold5", 5'd5, 1'b1, 1'b1, 5'd5, 5'd0, 5'd2, 5'd0, 1'b0);
        drive(5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd2, 5'd0, 1'b0);
        sampleCheck("afterHold");
        checkVal("afterHold.fAE", {30'd0, forwardAE}, 32'd2);
        clockEdge();

        // Keep stalling so the narrow-limit counter saturates.
        for (int i = 0; i < 5; i++) begin
            cycle("sat", 5'd12, 1'b1, 1'b0, 5'd12, 5'd0, 5'd0, 5'd0, 1'b0);
        end
        drive(5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        sampleCheck("satDone");
        checkVal("satDone.const", satCnt, 32'd3);
        clockEdge();

        // Asynchronous reset between edges with writeregM=7 and an EX-driven stall pending.
        cycle("pre7", 5'd7, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        drive(5'd4, 1'b1, 1'b0, 5'd0, 5'd4, 5'd7, 5'd0, 1'b0);
        sampleCheck("pre7fwd");
        #2;
        rst = 1'b1;
        modelReset();
        sampleCheck("asyncRst");
        checkVal("asyncRst.fAE", {30'd0, forwardAE}, 32'd0);
        checkVal("asyncRst.cnt", stall_cnt, 32'd0);
        checkVal("asyncRst.eStall", {31'd0, stallD}, 32'd1);
        clockEdge();
        rst = 1'b0;

        // Random traffic over a small register range so matches are frequent.
        for (int i = 0; i < 300; i++) begin
            cycle("rand", 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
